// File: rtl/glove_pkg.sv
// Shared definitions for the glove tracking pipeline: default geometry and
// counter widths, detection threshold, and the centroid controller states.
package glove_pkg;

    localparam int unsigned GLOVE_XW         = 10;  // 640 active columns
    localparam int unsigned GLOVE_YW         = 10;  // 480 active rows
    localparam int unsigned GLOVE_CNT_W      = 19;  // holds 640*480 pixels
    localparam int unsigned GLOVE_SUM_W      = 28;  // full-frame coordinate sums
    localparam int unsigned GLOVE_MIN_PIXELS = 64;  // smallest blob we trust

    typedef enum logic [1:0] {
        StIdle,
        StDivX,
        StDivY,
        StDone
    } glove_state_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// start_i loads the operands and performs the first iteration on the same
// edge; the quotient is final after SUM_W edges in total. last_o flags the
// cycle whose closing edge performs the final iteration.
module serial_divider
    import glove_pkg::*;
#(
    parameter int unsigned SUM_W = GLOVE_SUM_W,
    parameter int unsigned CNT_W = GLOVE_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [SUM_W-1:0] quotient_o
);

    localparam int unsigned IterW = $clog2(SUM_W + 1);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [IterW-1:0] iter_q, iter_d;

    logic [CNT_W-1:0] rem_in;
    logic [SUM_W-1:0] quo_in;
    logic [CNT_W-1:0] dv;
    logic [CNT_W:0]   shifted;
    logic [CNT_W+1:0] trial;
    logic             borrow;

    assign busy_o     = (iter_q != '0);
    assign last_o     = (iter_q == IterW'(1));
    assign quotient_o = quo_q;

    // One restoring step; operands come from the ports on start, else from state.
    always_comb begin
        rem_in = rem_q;
        quo_in = quo_q;
        dv     = div_q;
        if (start_i) begin
            rem_in = '0;
            quo_in = dividend_i;
            dv     = divisor_i;
        end
        shifted = {rem_in, quo_in[SUM_W-1]};
        // Extra top bit so the borrow is visible even when shifted's MSB is set.
        trial   = {1'b0, shifted} - {2'b00, dv};
        borrow  = trial[CNT_W+1];

        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        iter_d = iter_q;
        if (start_i || busy_o) begin
            // On no borrow the remainder is < dv, so the MSB dropped here is zero.
            rem_d  = borrow ? shifted[CNT_W-1:0] : trial[CNT_W-1:0];
            quo_d  = {quo_in[SUM_W-2:0], ~borrow};
            div_d  = dv;
            iter_d = start_i ? IterW'(SUM_W - 1) : iter_q - IterW'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
            iter_q <= iter_d;
        end
    end

endmodule

// File: rtl/glove_centroid.sv
// Per-glove centroid: accumulates matching-pixel X/Y sums and a count over a
// frame, then divides both sums by the count with one shared serial divider.
// One result per frame, out_valid exactly 2*SUM_W+1 clocks after frame_end.
// Optional bounding-box outputs are built when GLOVE_BBOX_EN is defined.
module glove_centroid
    import glove_pkg::*;
#(
    parameter int unsigned XW         = GLOVE_XW,
    parameter int unsigned YW         = GLOVE_YW,
    parameter int unsigned CNT_W      = GLOVE_CNT_W,
    parameter int unsigned SUM_W      = GLOVE_SUM_W,
    parameter int unsigned MIN_PIXELS = GLOVE_MIN_PIXELS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [XW-1:0]    pix_x,
    input  logic [YW-1:0]    pix_y,
    input  logic             pix_match,
    input  logic             frame_end,
    output logic             busy,
    output logic             out_valid,
    output logic             found,
    output logic [XW-1:0]    centroid_x,
    output logic [YW-1:0]    centroid_y,
`ifdef GLOVE_BBOX_EN
    output logic [XW-1:0]    bbox_xmin,
    output logic [XW-1:0]    bbox_xmax,
    output logic [YW-1:0]    bbox_ymin,
    output logic [YW-1:0]    bbox_ymax,
`endif
    output logic [CNT_W-1:0] pixel_count
);

    glove_state_e state_q, state_d;

    logic             accept;
    logic             frame_start;

    logic [SUM_W-1:0] sum_x_q, sum_x_d;
    logic [SUM_W-1:0] sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SUM_W-1:0] snap_x_q, snap_x_d;
    logic [SUM_W-1:0] snap_y_q, snap_y_d;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [XW-1:0]    quot_x_q, quot_x_d;

    logic             out_valid_q, out_valid_d;
    logic             found_q, found_d;
    logic [XW-1:0]    cx_q, cx_d;
    logic [YW-1:0]    cy_q, cy_d;
    logic [CNT_W-1:0] pcount_q, pcount_d;

    logic             div_start;
    logic [SUM_W-1:0] div_dividend;
    logic             div_busy;
    logic             div_last;
    logic [SUM_W-1:0] div_quotient;
    logic             unused_quot;

    assign accept      = pix_valid & pix_match;
    assign frame_start = (state_q == StIdle) & frame_end;
    // Only the low XW/YW quotient bits matter; the rest are always zero.
    assign unused_quot = ^div_quotient;

    assign busy        = (state_q != StIdle);
    assign out_valid   = out_valid_q;
    assign found       = found_q;
    assign centroid_x  = cx_q;
    assign centroid_y  = cy_q;
    assign pixel_count = pcount_q;

    // Frame accumulators; a pixel arriving with an accepted frame_end opens the next frame.
    always_comb begin
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        if (frame_start) begin
            sum_x_d = accept ? SUM_W'(pix_x) : '0;
            sum_y_d = accept ? SUM_W'(pix_y) : '0;
            cnt_d   = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            sum_x_d = sum_x_q + SUM_W'(pix_x);
            sum_y_d = sum_y_q + SUM_W'(pix_y);
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Controller: snapshot, divide X then Y, publish results for one cycle.
    always_comb begin
        state_d      = state_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_cnt_d   = snap_cnt_q;
        quot_x_d     = quot_x_q;
        out_valid_d  = 1'b0;
        found_d      = found_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        pcount_d     = pcount_q;
        div_start    = 1'b0;
        div_dividend = snap_x_q;

        unique case (state_q)
            StIdle: begin
                if (frame_end) begin
                    snap_x_d   = sum_x_q;
                    snap_y_d   = sum_y_q;
                    snap_cnt_d = cnt_q;
                    state_d    = StDivX;
                end
            end
            StDivX: begin
                // Divider is idle only in the first DIVX cycle.
                div_start = ~div_busy;
                if (div_last) begin
                    state_d = StDivY;
                end
            end
            StDivY: begin
                div_dividend = snap_y_q;
                div_start    = ~div_busy;
                // X quotient is final in the first DIVY cycle, before Y overwrites it.
                if (!div_busy) begin
                    quot_x_d = div_quotient[XW-1:0];
                end
                if (div_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_d = 1'b1;
                pcount_d    = snap_cnt_q;
                found_d     = (snap_cnt_q >= CNT_W'(MIN_PIXELS));
                // Small or empty blobs keep the previous centroid; a zero divisor never leaks.
                if (found_d) begin
                    cx_d = quot_x_q;
                    cy_d = div_quotient[YW-1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            cnt_q       <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_cnt_q  <= '0;
            quot_x_q    <= '0;
            out_valid_q <= 1'b0;
            found_q     <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            pcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_cnt_q  <= snap_cnt_d;
            quot_x_q    <= quot_x_d;
            out_valid_q <= out_valid_d;
            found_q     <= found_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            pcount_q    <= pcount_d;
        end
    end

    serial_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (snap_cnt_q),
        .busy_o     (div_busy),
        .last_o     (div_last),
        .quotient_o (div_quotient)
    );

`ifdef GLOVE_BBOX_EN
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [XW-1:0] snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
    logic [YW-1:0] snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;
    logic [XW-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
    logic [YW-1:0] bymin_q, bymin_d, bymax_q, bymax_d;

    assign bbox_xmin = bxmin_q;
    assign bbox_xmax = bxmax_q;
    assign bbox_ymin = bymin_q;
    assign bbox_ymax = bymax_q;

    // Per-frame extents; reopened with the frame_end pixel just like the sums.
    always_comb begin
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        snap_xmin_d = snap_xmin_q;
        snap_xmax_d = snap_xmax_q;
        snap_ymin_d = snap_ymin_q;
        snap_ymax_d = snap_ymax_q;
        bxmin_d     = bxmin_q;
        bxmax_d     = bxmax_q;
        bymin_d     = bymin_q;
        bymax_d     = bymax_q;
        if (frame_start) begin
            snap_xmin_d = xmin_q;
            snap_xmax_d = xmax_q;
            snap_ymin_d = ymin_q;
            snap_ymax_d = ymax_q;
            xmin_d      = accept ? pix_x : '1;
            xmax_d      = accept ? pix_x : '0;
            ymin_d      = accept ? pix_y : '1;
            ymax_d      = accept ? pix_y : '0;
        end else if (accept) begin
            if (pix_x < xmin_q) xmin_d = pix_x;
            if (pix_x > xmax_q) xmax_d = pix_x;
            if (pix_y < ymin_q) ymin_d = pix_y;
            if (pix_y > ymax_q) ymax_d = pix_y;
        end
        if (state_q == StDone && found_d) begin
            bxmin_d = snap_xmin_q;
            bxmax_d = snap_xmax_q;
            bymin_d = snap_ymin_q;
            bymax_d = snap_ymax_q;
        end
    end

    // Bounding-box registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            snap_xmin_q <= '0;
            snap_xmax_q <= '0;
            snap_ymin_q <= '0;
            snap_ymax_q <= '0;
            bxmin_q     <= '0;
            bxmax_q     <= '0;
            bymin_q     <= '0;
            bymax_q     <= '0;
        end else begin
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            snap_xmin_q <= snap_xmin_d;
            snap_xmax_q <= snap_xmax_d;
            snap_ymin_q <= snap_ymin_d;
            snap_ymax_q <= snap_ymax_d;
            bxmin_q     <= bxmin_d;
            bxmax_q     <= bxmax_d;
            bymin_q     <= bymin_d;
            bymax_q     <= bymax_d;
        end
    end
`endif

endmodule

// File: tb/tb_glove_centroid.sv
// Scoreboard bench for glove_centroid: the stimulus process keeps a frame
// model (plain sums and a division) and queues one expected result per
// accepted frame_end; the monitor checks every cycle at the falling edge.
module tb_glove_centroid;

    localparam int XW         = 10;
    localparam int YW         = 10;
    localparam int CNT_W      = 19;
    localparam int SUM_W      = 28;
    localparam int MIN_PIXELS = 64;
    localparam int LAT        = 2 * SUM_W + 1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             pix_valid = 1'b0;
    logic [XW-1:0]    pix_x     = '0;
    logic [YW-1:0]    pix_y     = '0;
    logic             pix_match = 1'b0;
    logic             frame_end = 1'b0;
    logic             busy;
    logic             out_valid;
    logic             found;
    logic [XW-1:0]    centroid_x;
    logic [YW-1:0]    centroid_y;
    logic [CNT_W-1:0] pixel_count;
`ifdef GLOVE_BBOX_EN
    logic [XW-1:0]    bbox_xmin, bbox_xmax;
    logic [YW-1:0]    bbox_ymin, bbox_ymax;
`endif

    always #5 clk = ~clk;

    glove_centroid dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_match   (pix_match),
        .frame_end   (frame_end),
        .busy        (busy),
        .out_valid   (out_valid),
        .found       (found),
        .centroid_x  (centroid_x),
        .centroid_y  (centroid_y),
`ifdef GLOVE_BBOX_EN
        .bbox_xmin   (bbox_xmin),
        .bbox_xmax   (bbox_xmax),
        .bbox_ymin   (bbox_ymin),
        .bbox_ymax   (bbox_ymax),
`endif
        .pixel_count (pixel_count)
    );

    typedef struct packed {
        longint      cyc;
        logic        found;
        int unsigned cnt;
        int unsigned cx;
        int unsigned cy;
        int unsigned bx0;
        int unsigned bx1;
        int unsigned by0;
        int unsigned by1;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    longint cyc      = 0;

    // Frame model: what the DUT should be accumulating right now.
    longint k_prev = -1000;  // edge at which the last accepted frame_end was sampled
    longint m_sx, m_sy;
    int     m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
    int     p_cx, p_cy, p_bx0, p_bx1, p_by0, p_by1;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        m_xmin = (1 << XW) - 1; m_xmax = 0;
        m_ymin = (1 << YW) - 1; m_ymax = 0;
    endtask

    task automatic model_add(input int x, input int y);
        m_sx += x; m_sy += y; m_cnt++;
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
    endtask

    // Drive one clock of stimulus and advance the model accordingly.
    task automatic step(input logic v, input int x, input int y, input logic m, input logic fe);
        exp_t e;
        pix_valid = v;
        pix_x     = XW'(x);
        pix_y     = YW'(y);
        pix_match = m;
        frame_end = fe;
        // Sampled at edge cyc+1; accepted only once the previous result is out.
        if (fe && (cyc + 1 >= k_prev + LAT + 1)) begin
            e.cyc   = cyc + 1 + LAT;
            e.cnt   = m_cnt;
            e.found = (m_cnt >= MIN_PIXELS);
            if (e.found) begin
                p_cx  = int'(m_sx / m_cnt);
                p_cy  = int'(m_sy / m_cnt);
                p_bx0 = m_xmin; p_bx1 = m_xmax;
                p_by0 = m_ymin; p_by1 = m_ymax;
            end
            e.cx  = p_cx;  e.cy  = p_cy;
            e.bx0 = p_bx0; e.bx1 = p_bx1;
            e.by0 = p_by0; e.by1 = p_by1;
            exp_q.push_back(e);
            k_prev = cyc + 1;
            model_clear();
            if (v && m) model_add(x, y);
        end else if (v && m) begin
            model_add(x, y);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready();
        while (cyc + 1 < k_prev + LAT + 1) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        k_prev = -1000;
        model_clear();
        p_cx = 0; p_cy = 0; p_bx0 = 0; p_bx1 = 0; p_by0 = 0; p_by1 = 0;
        idle(3);
        reset = 1'b0;
    endtask

    task automatic block_frame();
        for (int y = 200; y <= 207; y++)
            for (int x = 100; x <= 107; x++) step(1'b1, x, y, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // Exactly n matching pixels at random positions, interleaved with non-matching ones.
    task automatic n_match_frame(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, $urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1'b0);
            step(1'b1, $urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic random_frame(input int len);
        for (int i = 0; i < len; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 639), $urandom_range(0, 479),
                 $urandom_range(0, 1) == 1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    function automatic logic exp_busy(input longint c);
        longint d;
        d = c - k_prev;
        return (d >= 0) && (d <= 2 * SUM_W);
    endfunction

    // Monitor: pops an expectation on every out_valid, checks outputs every cycle.
    initial begin
        exp_t e;
        exp_t cur;
        cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                cur = '0;
            end else begin
                chk("busy", busy, exp_busy(cyc));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_valid_cycle", cyc, e.cyc);
                        cur = e;
                    end
                end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
                    chk("missing_out_valid", out_valid, 1);
                    cur = exp_q.pop_front();
                end
                chk("found", found, cur.found);
                chk("pixel_count", pixel_count, cur.cnt);
                chk("centroid_x", centroid_x, cur.cx);
                chk("centroid_y", centroid_y, cur.cy);
`ifdef GLOVE_BBOX_EN
                chk("bbox_xmin", bbox_xmin, cur.bx0);
                chk("bbox_xmax", bbox_xmax, cur.bx1);
                chk("bbox_ymin", bbox_ymin, cur.by0);
                chk("bbox_ymax", bbox_ymax, cur.by1);
`endif
            end
        end
    end

    initial begin
        model_clear();
        do_reset();
        idle(2);

        // 8x8 block -> (103,203), count 64, found
        block_frame();
        wait_ready();
        // 10 matches -> not found, centroid held
        n_match_frame(10);
        wait_ready();
        // no matches at all
        for (int i = 0; i < 50; i++) step(1'b1, i, i, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        wait_ready();
        // threshold boundary
        n_match_frame(MIN_PIXELS - 1);
        wait_ready();
        n_match_frame(MIN_PIXELS);
        wait_ready();
        // random frames straddling the threshold
        for (int f = 0; f < 6; f++) begin
            random_frame($urandom_range(40, 300));
            wait_ready();
        end
        // extreme coordinates -> (319,239)
        for (int i = 0; i < 2000; i++) step(1'b1, 639, 479, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) step(1'b1, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        wait_ready();
        // pixel (5,5) with frame_end belongs to the next frame; frame_end at +20 ignored
        for (int i = 0; i < 70; i++) step(1'b1, 300 + (i % 7), 100 + i, 1'b1, 1'b0);
        step(1'b1, 5, 5, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) step(1'b1, 600, 400, (i % 2) == 0, 1'b0);
        step(1'b1, 610, 410, 1'b1, 1'b1);
        wait_ready();
        for (int i = 0; i < 60; i++) step(1'b1, 10 + i, 20, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        wait_ready();
        // reset during the X divide aborts the result
        block_frame();
        idle(19);
        do_reset();
        idle(LAT + 10);
        block_frame();
        wait_ready();
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
